// File: rtl/tdm_demux_pkg.sv
// ---------------------------------------------------------------------------
// tdm_demux_pkg
//   Shared types and helpers for the TDM receive path (tdm_demux and its
//   slot counter).
//     state_e : FSM state encoding, IDLE=1'b0 (waiting for slot 0),
//               RECV=1'b1 (collecting slots 1..CH_NUM-1)
//     cnt_w() : width of the slot counter for a given channel count
// ---------------------------------------------------------------------------
package tdm_demux_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_e;

  function automatic int cnt_w(input int ch_num);
    return $clog2(ch_num);
  endfunction

endpackage

// File: rtl/tdm_slot_cnt.sv
// ---------------------------------------------------------------------------
// tdm_slot_cnt
//   Slot index counter for the TDM demux. Holds the index of the next slot
//   to be written into the shadow buffer.
//   Ports:
//     sys_clk  in   system clock, rising edge
//     sys_rst  in   synchronous reset, active-high (cnt -> 0)
//     clr      in   cnt <= 0            (highest priority)
//     load1    in   cnt <= 1            (slot 0 just accepted)
//     inc      in   cnt <= cnt + 1      (ignored once cnt is at the last slot)
//     cnt      out  current slot index, $clog2(CH_NUM) bits
//     last     out  cnt == CH_NUM-1
// ---------------------------------------------------------------------------
module tdm_slot_cnt
  import tdm_demux_pkg::*;
#(
  parameter int CH_NUM = 2
) (
  input  logic                        sys_clk,
  input  logic                        sys_rst,
  input  logic                        clr,
  input  logic                        load1,
  input  logic                        inc,
  output logic [cnt_w(CH_NUM)-1:0]    cnt,
  output logic                        last
);

  localparam int CW = cnt_w(CH_NUM);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign last = (cnt_q == CW'(CH_NUM - 1));
  assign cnt  = cnt_q;

  // NOTE: every always_comb output gets a default on its first line; a path
  // that leaves it unassigned would infer a latch.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (load1) begin
      cnt_d = CW'(1);
    end else if (inc && !last) begin
      // Saturate at the last slot so the index never wraps.
      cnt_d = cnt_q + 1'b1;
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples the pre-edge value of every other flop.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/tdm_demux.sv
// ---------------------------------------------------------------------------
// tdm_demux
//   Receive side of the channel-select mux path. Collects CH_NUM consecutive
//   slot samples (slot 0 flagged by in_sof) into a shadow buffer and publishes
//   them as one parallel word only when the whole frame has arrived, so the
//   outputs never show a partial frame.
//   Ports:
//     sys_clk    in   system clock, rising edge
//     sys_rst    in   synchronous reset, active-high
//     in_data    in   DATA_W     slot sample
//     in_valid   in   1          in_data/in_sof qualify this cycle
//     in_sof     in   1          sample is slot 0 of a frame
//     out_data   out  CH_NUM*DATA_W last complete frame, slot i at [i*DATA_W +: DATA_W]
//     out_valid  out  1          one-cycle pulse, out_data just updated
//     err_sync   out  1          one-cycle pulse, framing error seen
//     err_cnt    out  8          (TDM_DEMUX_ERRCNT_EN only) saturating count
//                                of err_sync pulses
//   Build option: define TDM_DEMUX_ERRCNT_EN to add the err_cnt port and its
//   counter; otherwise neither exists.
// ---------------------------------------------------------------------------
module tdm_demux
  import tdm_demux_pkg::*;
#(
  parameter int CH_NUM = 2,
  parameter int DATA_W = 1
) (
  input  logic                       sys_clk,
  input  logic                       sys_rst,
  input  logic [DATA_W-1:0]          in_data,
  input  logic                       in_valid,
  input  logic                       in_sof,
  output logic [CH_NUM*DATA_W-1:0]   out_data,
  output logic                       out_valid,
  output logic                       err_sync
`ifdef TDM_DEMUX_ERRCNT_EN
  ,
  output logic [7:0]                 err_cnt
`endif
);

  localparam int CW   = cnt_w(CH_NUM);
  localparam int SH_W = (CH_NUM - 1) * DATA_W;

  state_e                      state_q, state_d;
  logic [SH_W-1:0]             shadow_q, shadow_d;
  logic [CH_NUM*DATA_W-1:0]    out_data_q, out_data_d;
  logic                        out_valid_q, out_valid_d;
  logic                        err_sync_q, err_sync_d;

  logic                        cnt_clr;
  logic                        cnt_load1;
  logic                        cnt_inc;
  logic [CW-1:0]               cnt;
  logic                        cnt_last;

  tdm_slot_cnt #(
    .CH_NUM (CH_NUM)
  ) u_slot_cnt (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .clr     (cnt_clr),
    .load1   (cnt_load1),
    .inc     (cnt_inc),
    .cnt     (cnt),
    .last    (cnt_last)
  );

  always_comb begin
    state_d     = state_q;
    shadow_d    = shadow_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    err_sync_d  = 1'b0;
    cnt_clr     = 1'b0;
    cnt_load1   = 1'b0;
    cnt_inc     = 1'b0;

    if (in_valid) begin
      case (state_q)
        IDLE: begin
          if (in_sof) begin
            shadow_d[DATA_W-1:0] = in_data;
            cnt_load1            = 1'b1;
            state_d              = RECV;
          end else begin
            // Sample outside any frame: dropped.
            err_sync_d = 1'b1;
          end
        end
        RECV: begin
          if (in_sof) begin
            // Short frame; sof wins even on the last slot. Restart from slot 0.
            err_sync_d           = 1'b1;
            shadow_d[DATA_W-1:0] = in_data;
            cnt_load1            = 1'b1;
          end else if (cnt_last) begin
            // Last slot goes straight to the output, never via the shadow.
            out_data_d  = {in_data, shadow_q};
            out_valid_d = 1'b1;
            cnt_clr     = 1'b1;
            state_d     = IDLE;
          end else begin
            for (int i = 0; i < CH_NUM - 1; i++) begin
              if (cnt == CW'(i)) begin
                shadow_d[i*DATA_W +: DATA_W] = in_data;
              end
            end
            cnt_inc = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: the shadow buffer is reset along with the control flops so a reset
  // mid-frame leaves no stale slot data that could be observed later.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q     <= IDLE;
      shadow_q    <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      err_sync_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      shadow_q    <= shadow_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      err_sync_q  <= err_sync_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign err_sync  = err_sync_q;

`ifdef TDM_DEMUX_ERRCNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  // Counts on the same edge that raises err_sync; sticks at 8'hFF.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_sync_d && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      err_cnt_q <= 8'd0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_tdm_demux.sv
// ---------------------------------------------------------------------------
// tb_tdm_demux
//   Two instances: dut_a (CH_NUM=2, DATA_W=1) and dut_b (CH_NUM=4, DATA_W=8).
//   Each has a reference model that keeps the current partial frame as a
//   queue of samples: sof restarts the queue, a non-sof sample with an empty
//   queue is a sync error, and a queue reaching CH_NUM entries is published.
// ---------------------------------------------------------------------------
module tb_tdm_demux;

  logic        sys_clk;
  int          checks;
  int          failures;

  // dut_a signals
  logic        rst_a, v_a, sof_a;
  logic [0:0]  d_a;
  logic [1:0]  od_a;
  logic        ov_a, es_a;
  // dut_b signals
  logic        rst_b, v_b, sof_b;
  logic [7:0]  d_b;
  logic [31:0] od_b;
  logic        ov_b, es_b;
`ifdef TDM_DEMUX_ERRCNT_EN
  logic [7:0]  ec_a, ec_b;
`endif

  // Reference model state
  logic [0:0]  qa[$];
  logic [1:0]  ea_data;
  logic        ea_valid, ea_err;
  int          ea_cnt;
  logic [7:0]  qb[$];
  logic [31:0] eb_data;
  logic        eb_valid, eb_err;
  int          eb_cnt;

  tdm_demux #(.CH_NUM(2), .DATA_W(1)) dut_a (
    .sys_clk  (sys_clk),
    .sys_rst  (rst_a),
    .in_data  (d_a),
    .in_valid (v_a),
    .in_sof   (sof_a),
    .out_data (od_a),
    .out_valid(ov_a),
    .err_sync (es_a)
`ifdef TDM_DEMUX_ERRCNT_EN
    ,
    .err_cnt  (ec_a)
`endif
  );

  tdm_demux #(.CH_NUM(4), .DATA_W(8)) dut_b (
    .sys_clk  (sys_clk),
    .sys_rst  (rst_b),
    .in_data  (d_b),
    .in_valid (v_b),
    .in_sof   (sof_b),
    .out_data (od_b),
    .out_valid(ov_b),
    .err_sync (es_b)
`ifdef TDM_DEMUX_ERRCNT_EN
    ,
    .err_cnt  (ec_b)
`endif
  );

  always #5 sys_clk = ~sys_clk;

  // Drive one cycle on dut_a, advance the model, sample 1 time unit after the edge.
  task automatic drive_a(input logic v, input logic s, input logic [0:0] d);
    v_a = v; sof_a = s; d_a = d;
    ea_valid = 1'b0; ea_err = 1'b0;
    if (v) begin
      if (s) begin
        if (qa.size() != 0) ea_err = 1'b1;
        qa.delete();
        qa.push_back(d);
      end else if (qa.size() == 0) begin
        ea_err = 1'b1;
      end else begin
        qa.push_back(d);
        if (qa.size() == 2) begin
          for (int i = 0; i < 2; i++) ea_data[i] = qa[i];
          ea_valid = 1'b1;
          qa.delete();
        end
      end
    end
    if (ea_err && ea_cnt < 255) ea_cnt++;
    @(posedge sys_clk); #1;
  endtask

  task automatic drive_b(input logic v, input logic s, input logic [7:0] d);
    v_b = v; sof_b = s; d_b = d;
    eb_valid = 1'b0; eb_err = 1'b0;
    if (v) begin
      if (s) begin
        if (qb.size() != 0) eb_err = 1'b1;
        qb.delete();
        qb.push_back(d);
      end else if (qb.size() == 0) begin
        eb_err = 1'b1;
      end else begin
        qb.push_back(d);
        if (qb.size() == 4) begin
          for (int i = 0; i < 4; i++) eb_data[i*8 +: 8] = qb[i];
          eb_valid = 1'b1;
          qb.delete();
        end
      end
    end
    if (eb_err && eb_cnt < 255) eb_cnt++;
    @(posedge sys_clk); #1;
  endtask

  task automatic reset_b_cycle();
    rst_b = 1'b1; v_b = 1'b0; sof_b = 1'b0; d_b = '0;
    qb.delete(); eb_data = '0; eb_valid = 1'b0; eb_err = 1'b0; eb_cnt = 0;
    @(posedge sys_clk); #1;
    rst_b = 1'b0;
  endtask

  task automatic test_reset();
    rst_a = 1'b1; rst_b = 1'b1;
    v_a = 1'b0; sof_a = 1'b0; d_a = '0;
    v_b = 1'b1; sof_b = 1'b1; d_b = 8'h5A;  // reset must dominate valid input
    qa.delete(); qb.delete();
    ea_data = '0; ea_valid = 1'b0; ea_err = 1'b0; ea_cnt = 0;
    eb_data = '0; eb_valid = 1'b0; eb_err = 1'b0; eb_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge sys_clk); #1;
      checks++;
      if (od_a !== 2'b00 || ov_a !== 1'b0 || es_a !== 1'b0) begin
        failures++;
        $display("FAIL reset_a[%0d] got data=%b valid=%b err=%b exp 00/0/0", i, od_a, ov_a, es_a);
      end
      checks++;
      if (od_b !== 32'h0 || ov_b !== 1'b0 || es_b !== 1'b0) begin
        failures++;
        $display("FAIL reset_b[%0d] got data=%h valid=%b err=%b exp 0/0/0", i, od_b, ov_b, es_b);
      end
    end
    rst_a = 1'b0; rst_b = 1'b0; v_b = 1'b0; sof_b = 1'b0;
  endtask

  task automatic test_basic_frame();
    drive_a(1'b1, 1'b1, 1'b1);
    checks++;
    if (ov_a !== 1'b0 || es_a !== 1'b0 || od_a !== 2'b00) begin
      failures++;
      $display("FAIL basic_slot0 got data=%b valid=%b err=%b exp 00/0/0", od_a, ov_a, es_a);
    end
    drive_a(1'b1, 1'b0, 1'b0);
    checks++;
    if (od_a !== 2'b01 || ov_a !== 1'b1 || es_a !== 1'b0) begin
      failures++;
      $display("FAIL basic_done got data=%b valid=%b err=%b exp 01/1/0", od_a, ov_a, es_a);
    end
    drive_a(1'b0, 1'b0, 1'b0);
    checks++;
    if (od_a !== 2'b01 || ov_a !== 1'b0) begin
      failures++;
      $display("FAIL basic_hold got data=%b valid=%b exp 01/0", od_a, ov_a);
    end
  endtask

  task automatic test_gaps();
    logic [0:0] samp [2];
    samp[0] = 1'b1; samp[1] = 1'b0;
    for (int s = 0; s < 2; s++) begin
      drive_a(1'b1, (s == 0), samp[s]);
      checks++;
      if (od_a !== ea_data || ov_a !== ea_valid || es_a !== ea_err) begin
        failures++;
        $display("FAIL gaps_slot%0d got %b/%b/%b exp %b/%b/%b", s, od_a, ov_a, es_a, ea_data, ea_valid, ea_err);
      end
      if (s == 0) begin
        for (int g = 0; g < 3; g++) begin
          drive_a(1'b0, 1'b1, 1'b0);  // sof/data ignored while not valid
          checks++;
          if (ov_a !== 1'b0 || es_a !== 1'b0) begin
            failures++;
            $display("FAIL gaps_idle%0d got valid=%b err=%b exp 0/0", g, ov_a, es_a);
          end
        end
      end
    end
    checks++;
    if (od_a !== 2'b01 || ov_a !== 1'b1) begin
      failures++;
      $display("FAIL gaps_done got data=%b valid=%b exp 01/1", od_a, ov_a);
    end
  endtask

  task automatic test_short_frame();
    drive_a(1'b1, 1'b1, 1'b1);
    drive_a(1'b1, 1'b1, 1'b0);
    checks++;
    if (es_a !== 1'b1 || ov_a !== 1'b0 || od_a !== 2'b01) begin
      failures++;
      $display("FAIL short_resync got err=%b valid=%b data=%b exp 1/0/01", es_a, ov_a, od_a);
    end
    drive_a(1'b1, 1'b0, 1'b1);
    checks++;
    if (od_a !== 2'b10 || ov_a !== 1'b1 || es_a !== 1'b0) begin
      failures++;
      $display("FAIL short_done got data=%b valid=%b err=%b exp 10/1/0", od_a, ov_a, es_a);
    end
  endtask

  task automatic test_idle_error();
    drive_a(1'b1, 1'b0, 1'b1);
    checks++;
    if (es_a !== 1'b1 || ov_a !== 1'b0 || od_a !== 2'b10) begin
      failures++;
      $display("FAIL idle_err got err=%b valid=%b data=%b exp 1/0/10", es_a, ov_a, od_a);
    end
    drive_a(1'b0, 1'b0, 1'b0);
    checks++;
    if (es_a !== 1'b0) begin
      failures++;
      $display("FAIL idle_err_pulse got err=%b exp 0", es_a);
    end
`ifdef TDM_DEMUX_ERRCNT_EN
    for (int i = 0; i < 300; i++) drive_a(1'b1, 1'b0, 1'b0);
    checks++;
    if (ec_a !== 8'hFF) begin
      failures++;
      $display("FAIL errcnt_sat got err_cnt=%h exp ff", ec_a);
    end
`endif
  endtask

  task automatic test_random_a();
    for (int i = 0; i < 300; i++) begin
      drive_a($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, 1'($urandom));
      checks++;
      if (od_a !== ea_data || ov_a !== ea_valid || es_a !== ea_err) begin
        failures++;
        $display("FAIL rand_a[%0d] got %b/%b/%b exp %b/%b/%b", i, od_a, ov_a, es_a, ea_data, ea_valid, ea_err);
      end
`ifdef TDM_DEMUX_ERRCNT_EN
      checks++;
      if (ec_a !== 8'(ea_cnt)) begin
        failures++;
        $display("FAIL rand_a_cnt[%0d] got %0d exp %0d", i, ec_a, ea_cnt);
      end
`endif
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] slot [4];
    int pulses;
    slot[0] = 8'hAA; slot[1] = 8'hBB; slot[2] = 8'hCC; slot[3] = 8'hDD;
    pulses = 0;
    for (int n = 0; n < 8; n++) begin
      drive_b(1'b1, (n % 4) == 0, slot[n % 4]);
      if (ov_b === 1'b1) pulses++;
      checks++;
      if (od_b !== eb_data || ov_b !== eb_valid || es_b !== eb_err) begin
        failures++;
        $display("FAIL b2b[%0d] got %h/%b/%b exp %h/%b/%b", n, od_b, ov_b, es_b, eb_data, eb_valid, eb_err);
      end
    end
    checks++;
    if (pulses != 2 || od_b !== 32'hDDCCBBAA) begin
      failures++;
      $display("FAIL b2b_total got pulses=%0d data=%h exp 2/ddccbbaa", pulses, od_b);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] slot [4];
    slot[0] = 8'hAA; slot[1] = 8'hBB; slot[2] = 8'hCC; slot[3] = 8'hDD;
    drive_b(1'b1, 1'b1, slot[0]);
    drive_b(1'b1, 1'b0, slot[1]);
    reset_b_cycle();
    checks++;
    if (od_b !== 32'h0 || ov_b !== 1'b0 || es_b !== 1'b0) begin
      failures++;
      $display("FAIL midrst got data=%h valid=%b err=%b exp 0/0/0", od_b, ov_b, es_b);
    end
    // Continuing the old frame must now be a sync error, not slot 2.
    drive_b(1'b1, 1'b0, slot[2]);
    checks++;
    if (es_b !== 1'b1 || ov_b !== 1'b0) begin
      failures++;
      $display("FAIL midrst_stale got err=%b valid=%b exp 1/0", es_b, ov_b);
    end
    for (int n = 0; n < 4; n++) drive_b(1'b1, n == 0, slot[n]);
    checks++;
    if (od_b !== 32'hDDCCBBAA || ov_b !== 1'b1 || es_b !== 1'b0) begin
      failures++;
      $display("FAIL midrst_next got data=%h valid=%b err=%b exp ddccbbaa/1/0", od_b, ov_b, es_b);
    end
  endtask

  task automatic test_random_b();
    for (int i = 0; i < 400; i++) begin
      drive_b($urandom_range(0, 4) != 0, $urandom_range(0, 4) == 0, 8'($urandom));
      checks++;
      if (od_b !== eb_data || ov_b !== eb_valid || es_b !== eb_err) begin
        failures++;
        $display("FAIL rand_b[%0d] got %h/%b/%b exp %h/%b/%b", i, od_b, ov_b, es_b, eb_data, eb_valid, eb_err);
      end
`ifdef TDM_DEMUX_ERRCNT_EN
      checks++;
      if (ec_b !== 8'(eb_cnt)) begin
        failures++;
        $display("FAIL rand_b_cnt[%0d] got %0d exp %0d", i, ec_b, eb_cnt);
      end
`endif
    end
  endtask

  initial begin
    sys_clk  = 1'b0;
    checks   = 0;
    failures = 0;
    rst_a = 1'b1; v_a = 1'b0; sof_a = 1'b0; d_a = '0;
    rst_b = 1'b1; v_b = 1'b0; sof_b = 1'b0; d_b = '0;
    #2;
    test_reset();
    test_basic_frame();
    test_gaps();
    test_short_frame();
    test_idle_error();
    test_random_a();
    test_back_to_back();
    test_reset_mid_frame();
    test_random_b();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
